// File: rtl/crossbar_switch_if.sv
// Request/payload bundle between the input ports and the crossbar,
// plus the registered outputs returned by the switch.
interface crossbar_switch_if #(
  parameter int N      = 4,
  parameter int M      = 4,
  parameter int DATA_W = 32,
  parameter int DEST_W = (M > 1) ? $clog2(M) : 1
);
  logic [N-1:0]             req;
  logic [N-1:0][DEST_W-1:0] dest;
  logic [N-1:0][DATA_W-1:0] data_in;
  logic [M-1:0][DATA_W-1:0] data_out;
  logic [N-1:0]             grant;

  modport master (
    output req,
    output dest,
    output data_in,
    input  data_out,
    input  grant
  );

  modport slave (
    input  req,
    input  dest,
    input  data_in,
    output data_out,
    output grant
  );
endinterface

// File: rtl/crossbar_switch.sv
// N x M crossbar with an independent round-robin arbiter per output;
// payload and grant are registered, one cycle of latency.
module crossbar_switch #(
  parameter int N      = 4,
  parameter int M      = 4,
  parameter int DATA_W = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  crossbar_switch_if.slave bus
);
  localparam int DEST_W = (M > 1) ? $clog2(M) : 1;
  localparam int IDX_W  = (N > 1) ? $clog2(N) : 1;

  logic [M-1:0][IDX_W-1:0]  ptr;
  logic [M-1:0][IDX_W-1:0]  ptr_nxt;
  logic [M-1:0][IDX_W-1:0]  win;
  logic [M-1:0]             hit;
  logic [IDX_W-1:0]         cand;
  logic [M-1:0][DATA_W-1:0] data_nxt;
  logic [N-1:0]             grant_nxt;

  function automatic logic [IDX_W-1:0] wrap(
    input logic [IDX_W-1:0] p,
    input int               k
  );
    int s;
    s = int'(p) + k;
    if (s >= N) s = s - N;
    return IDX_W'(s);
  endfunction

  // Out-of-range dest never equals any j < M, so it is ignored.
  always_comb begin
    hit       = '0;
    win       = '0;
    cand      = '0;
    data_nxt  = '0;
    grant_nxt = '0;
    ptr_nxt   = ptr;
    for (int j = 0; j < M; j++) begin
      for (int k = 0; k < N; k++) begin
        cand = wrap(ptr[j], k);
        if (!hit[j] && bus.req[cand] &&
            bus.dest[cand] == DEST_W'(j)) begin
          hit[j] = 1'b1;
          win[j] = cand;
        end
      end
      if (hit[j]) begin
        data_nxt[j]       = bus.data_in[win[j]];
        grant_nxt[win[j]] = 1'b1;
        ptr_nxt[j]        = wrap(win[j], 1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr          <= '0;
      bus.data_out <= '0;
      bus.grant    <= '0;
    end else begin
      ptr          <= ptr_nxt;
      bus.data_out <= data_nxt;
      bus.grant    <= grant_nxt;
    end
  end
endmodule

// File: tb/tb_crossbar_switch.sv
// Crossbar bench: directed cases with literal expectations, then random
// traffic compared every cycle against a queue-free priority model.
module tb_crossbar_switch;
  localparam int N = 4;
  localparam int M = 4;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  bit   chk_en = 1'b0;

  crossbar_switch_if #(.N(N), .M(M), .DATA_W(W)) bus ();

  crossbar_switch #(.N(N), .M(M), .DATA_W(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: winner is the requester closest after ptr (mod N).
  int          mptr [M];
  logic [31:0] exp_data [M];
  logic [3:0]  exp_grant;
  int          best, bestd, dd;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int j = 0; j < M; j++) begin
        mptr[j] = 0;
        exp_data[j] = '0;
      end
      exp_grant = '0;
    end else begin
      exp_grant = '0;
      for (int j = 0; j < M; j++) begin
        best = -1;
        bestd = N;
        for (int i = 0; i < N; i++) begin
          if (bus.req[i] && int'(bus.dest[i]) == j) begin
            dd = (i - mptr[j] + N) % N;
            if (dd < bestd) begin
              bestd = dd;
              best = i;
            end
          end
        end
        if (best >= 0) begin
          exp_data[j] = bus.data_in[best];
          exp_grant[best] = 1'b1;
          mptr[j] = (best + 1) % N;
        end else begin
          exp_data[j] = '0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int j = 0; j < M; j++)
        chk($sformatf("model_data_out[%0d]", j),
            bus.data_out[j], exp_data[j]);
      chk("model_grant", {28'b0, bus.grant}, {28'b0, exp_grant});
    end
  end

  task automatic apply(input logic [3:0] r, input int dv [4],
                       input logic [31:0] xv [4]);
    @(negedge clk);
    #2;
    bus.req = r;
    for (int i = 0; i < N; i++) begin
      bus.dest[i]    = 2'(dv[i]);
      bus.data_in[i] = xv[i];
    end
  endtask

  task automatic lit(input string nm, input logic [3:0] g,
                     input logic [31:0] dv [4]);
    @(posedge clk);
    #1;
    for (int j = 0; j < M; j++)
      chk($sformatf("%s data_out[%0d]", nm, j), bus.data_out[j], dv[j]);
    chk({nm, " grant"}, {28'b0, bus.grant}, {28'b0, g});
  endtask

  task automatic zero_now(input string nm);
    for (int j = 0; j < M; j++)
      chk($sformatf("%s data_out[%0d]", nm, j), bus.data_out[j], 32'h0);
    chk({nm, " grant"}, {28'b0, bus.grant}, 32'h0);
  endtask

  task automatic mid_reset(input bit check);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    if (check) zero_now("async_reset");
    @(negedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  logic [31:0] id_data [4];
  logic [31:0] rx [4];
  int          rd [4];

  initial begin
    id_data = '{32'hA1A1A1A1, 32'hB2B2B2B2, 32'hC3C3C3C3, 32'hD4D4D4D4};
    bus.req = '0;
    bus.dest = '0;
    bus.data_in = '0;
    @(negedge clk);
    @(negedge clk);
    #1;
    zero_now("reset");
    chk_en = 1'b1;
    @(negedge clk);
    #1;
    rst_n = 1'b1;

    apply(4'b1111, '{0, 1, 2, 3}, id_data);
    lit("identity", 4'b1111, id_data);

    mid_reset(1'b0);
    apply(4'b1111, '{0, 3, 2, 3}, id_data);
    lit("conflict", 4'b0111,
        '{32'hA1A1A1A1, 32'h0, 32'hC3C3C3C3, 32'hB2B2B2B2});

    apply(4'b0101, '{2, 0, 2, 0},
          '{32'hDEADBEEF, 32'h1, 32'hCAFEBABE, 32'h3});
    lit("fair0", 4'b0001, '{32'h0, 32'h0, 32'hDEADBEEF, 32'h0});
    lit("fair1", 4'b0100, '{32'h0, 32'h0, 32'hCAFEBABE, 32'h0});
    lit("fair2", 4'b0001, '{32'h0, 32'h0, 32'hDEADBEEF, 32'h0});

    apply(4'b0001, '{2, 0, 0, 0}, '{32'hABCDEF01, 32'h5, 32'h6, 32'h7});
    lit("idle_one", 4'b0001, '{32'h0, 32'h0, 32'hABCDEF01, 32'h0});
    apply(4'b0000, '{2, 0, 0, 0}, '{32'hABCDEF01, 32'h5, 32'h6, 32'h7});
    lit("idle_none", 4'b0000, '{32'h0, 32'h0, 32'h0, 32'h0});

    apply(4'b0010, '{0, 1, 0, 0}, '{32'h0, 32'h12345678, 32'h0, 32'h0});
    lit("pre_reset", 4'b0010, '{32'h0, 32'h12345678, 32'h0, 32'h0});
    mid_reset(1'b1);
    apply(4'b0101, '{2, 0, 2, 0}, '{32'h11111111, 32'h0, 32'h22222222, 32'h0});
    lit("post_reset", 4'b0001, '{32'h0, 32'h0, 32'h11111111, 32'h0});

    apply(4'b1001, '{3, 0, 0, 0}, '{32'hFFFFFFFF, 32'h9, 32'h8, 32'h00000000});
    lit("swap", 4'b1001, '{32'h00000000, 32'h0, 32'h0, 32'hFFFFFFFF});

    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        rd[i] = int'($urandom_range(0, M - 1));
        rx[i] = $urandom;
      end
      apply(4'($urandom), rd, rx);
      if ($urandom_range(0, 63) == 0) mid_reset(1'b1);
    end

    apply(4'b0000, '{0, 0, 0, 0}, '{32'h0, 32'h0, 32'h0, 32'h0});
    @(negedge clk);
    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
